// File: rtl/i2c_bus_frontend.sv
// i2c_bus_frontend: line conditioning and event extraction for the I2C translator.
// Raw SCL/SDA pads are synchronised into clk and deglitched. The filtered lines
// produce single-cycle edge, START, repeated START and STOP strobes. Each byte and
// its ACK bit are deserialised for the downstream translator.
// Optional feature: define I2C_SCL_TIMEOUT_EN to build the SCL-low bus timeout.
// Without it, timeout is tied low and TO_W/TIMEOUT_CYC are unused.
module i2c_bus_frontend #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int TO_W        = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_f,
    output logic       sda_f,
    output logic       scl_rise,
    output logic       scl_fall,
    output logic       start_det,
    output logic       rstart_det,
    output logic       stop_det,
    output logic       bus_busy,
    output logic [3:0] bit_cnt,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       ack_bit,
    output logic       ack_valid,
    output logic       timeout
);

    localparam int FC_W = $clog2(FILT_LEN + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BITS = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   sda_s;
    logic [FC_W-1:0]        scl_cnt;
    logic [FC_W-1:0]        sda_cnt;
    logic                   scl_q;
    logic                   sda_q;
    logic                   start_cond;
    logic                   stop_cond;
    logic                   to_hit;
    logic [1:0]             state;
    logic [6:0]             shift_reg;

    // Bring both pad lines into the clk domain; idle-high reset avoids false edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // SCL deglitch: only a disagreement lasting FILT_LEN cycles flips the filtered line.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_f   <= 1'b1;
            scl_cnt <= '0;
        end else if (scl_s == scl_f) begin
            scl_cnt <= '0;
        end else if (scl_cnt == FC_W'(FILT_LEN - 1)) begin
            scl_f   <= scl_s;
            scl_cnt <= '0;
        end else begin
            scl_cnt <= scl_cnt + 1'b1;
        end
    end

    // SDA deglitch, identical to SCL so both lines see the same latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            sda_f   <= 1'b1;
            sda_cnt <= '0;
        end else if (sda_s == sda_f) begin
            sda_cnt <= '0;
        end else if (sda_cnt == FC_W'(FILT_LEN - 1)) begin
            sda_f   <= sda_s;
            sda_cnt <= '0;
        end else begin
            sda_cnt <= sda_cnt + 1'b1;
        end
    end

    // One-cycle-delayed copies of the filtered lines used for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    // SDA events only count when SCL was stable high across both cycles, so an
    // SCL edge coinciding with an SDA edge never produces START or STOP.
    assign scl_rise   = scl_f & ~scl_q;
    assign scl_fall   = ~scl_f & scl_q;
    assign start_cond = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_cond  = scl_f & scl_q & ~sda_q & sda_f;
    assign start_det  = start_cond & ~bus_busy;
    assign rstart_det = start_cond & bus_busy;
    assign stop_det   = stop_cond;

`ifdef I2C_SCL_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    assign to_hit = bus_busy && !scl_f && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Count SCL-low cycles during a transfer and pulse timeout when the limit is hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= to_hit;
            if (to_hit || !(bus_busy && !scl_f)) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end
`else
    localparam int unused_timeout_cfg = TO_W + TIMEOUT_CYC;

    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    // Transfer FSM: tracks busy, shifts data bits MSB first and captures the ACK bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bus_busy   <= 1'b0;
            bit_cnt    <= 4'd0;
            shift_reg  <= 7'd0;
            byte_data  <= 8'h00;
            byte_valid <= 1'b0;
            ack_bit    <= 1'b1;
            ack_valid  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            ack_valid  <= 1'b0;
            if (stop_cond || to_hit) begin
                state    <= ST_IDLE;
                bus_busy <= 1'b0;
                bit_cnt  <= 4'd0;
            end else if (start_cond) begin
                state    <= ST_BITS;
                bus_busy <= 1'b1;
                bit_cnt  <= 4'd0;
            end else if (scl_rise) begin
                case (state)
                    ST_BITS: begin
                        shift_reg <= {shift_reg[5:0], sda_f};
                        bit_cnt   <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            byte_data  <= {shift_reg, sda_f};
                            byte_valid <= 1'b1;
                            state      <= ST_ACK;
                        end
                    end
                    ST_ACK: begin
                        ack_bit   <= sda_f;
                        ack_valid <= 1'b1;
                        bit_cnt   <= 4'd0;
                        state     <= ST_BITS;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_bus_frontend.sv
// tb_i2c_bus_frontend: scoreboard bench for i2c_bus_frontend.
// Stimulus drives the raw pads and a pin-level I2C model pushes the expected events
// into a queue; an independent monitor pops and compares on every DUT strobe.
module tb_i2c_bus_frontend;

    localparam int SYNC = 2;
    localparam int FILT = 4;
    localparam int TOC  = 100;

    localparam int EV_START   = 0;
    localparam int EV_RSTART  = 1;
    localparam int EV_STOP    = 2;
    localparam int EV_BYTE    = 3;
    localparam int EV_ACK     = 4;
    localparam int EV_TIMEOUT = 5;

    typedef struct {
        int kind;
        int data;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       scl_i;
    logic       sda_i;
    logic       scl_f;
    logic       sda_f;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       rstart_det;
    logic       stop_det;
    logic       bus_busy;
    logic [3:0] bit_cnt;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       ack_bit;
    logic       ack_valid;
    logic       timeout;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    ev_t exp_q[$];

    // Protocol-level model of the bus as seen from the pins
    logic       m_busy      = 1'b0;
    int         m_nb        = 0;
    logic [7:0] m_cur       = 8'h00;
    logic [7:0] m_last_byte = 8'h00;
    logic       m_last_ack  = 1'b1;
    int         exp_rise    = 0;
    int         exp_fall    = 0;
    int         seen_rise   = 0;
    int         seen_fall   = 0;

    i2c_bus_frontend #(
        .SYNC_STAGES (SYNC),
        .FILT_LEN    (FILT),
        .TO_W        (16),
        .TIMEOUT_CYC (TOC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .scl_f      (scl_f),
        .sda_f      (sda_f),
        .scl_rise   (scl_rise),
        .scl_fall   (scl_fall),
        .start_det  (start_det),
        .rstart_det (rstart_det),
        .stop_det   (stop_det),
        .bus_busy   (bus_busy),
        .bit_cnt    (bit_cnt),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .ack_bit    (ack_bit),
        .ack_valid  (ack_valid),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter used to timestamp expected timeout pulses
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string ev_name(input int k);
        case (k)
            EV_START:   return "START";
            EV_RSTART:  return "RSTART";
            EV_STOP:    return "STOP";
            EV_BYTE:    return "BYTE";
            EV_ACK:     return "ACK";
            default:    return "TIMEOUT";
        endcase
    endfunction

    function automatic int rnd(input int unsigned lo, input int unsigned hi);
        return int'($urandom_range(hi, lo));
    endfunction

    task automatic push_ev(input int kind, input int data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_event(input int kind, input int data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_event: got %s data=%0d, expected none (cycle %0d)",
                     ev_name(kind), data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data != data) begin
                failures++;
                $display("[TB] FAIL event_order: got %s data=%0d, expected %s data=%0d (cycle %0d)",
                         ev_name(kind), data, ev_name(e.kind), e.data, cyc);
            end
        end
    endtask

    // Monitor: every DUT strobe consumes one expected event from the scoreboard
    always @(negedge clk) begin
        if (scl_rise)   seen_rise++;
        if (scl_fall)   seen_fall++;
        if (start_det)  check_event(EV_START, 0);
        if (rstart_det) check_event(EV_RSTART, 0);
        if (stop_det)   check_event(EV_STOP, 0);
        if (byte_valid) check_event(EV_BYTE, int'(byte_data));
        if (ack_valid)  check_event(EV_ACK, int'(ack_bit));
        if (timeout)    check_event(EV_TIMEOUT, cyc);
    end

    // Every SCL rise during a transfer samples SDA: 8 data bits, then the ACK bit
    task automatic model_rise(input logic d);
        if (m_busy) begin
            if (m_nb < 8) begin
                m_cur = {m_cur[6:0], d};
                m_nb++;
                if (m_nb == 8) begin
                    m_last_byte = m_cur;
                    push_ev(EV_BYTE, int'(m_cur));
                end
            end else begin
                m_last_ack = d;
                push_ev(EV_ACK, int'(d));
                m_nb = 0;
            end
        end
    endtask

    task automatic model_reset();
        m_busy      = 1'b0;
        m_nb        = 0;
        m_last_byte = 8'h00;
        m_last_ack  = 1'b1;
    endtask

    // Drive new pin levels, update the model, then hold them for 'hold' cycles
    task automatic apply_stimulus(input logic ns, input logic nd, input int hold);
        logic os;
        logic od;
        os    = scl_i;
        od    = sda_i;
        scl_i = ns;
        sda_i = nd;
        if (ns != os) begin
            if (ns) begin
                exp_rise++;
                model_rise(nd);
            end else begin
                exp_fall++;
`ifdef I2C_SCL_TIMEOUT_EN
                if (m_busy && hold > TOC + SYNC + FILT + 2) begin
                    push_ev(EV_TIMEOUT, cyc + SYNC + FILT + TOC);
                    m_busy = 1'b0;
                    m_nb   = 0;
                end
`endif
            end
        end else if (nd != od && ns) begin
            if (!nd) begin
                push_ev(m_busy ? EV_RSTART : EV_START, 0);
                m_busy = 1'b1;
                m_nb   = 0;
            end else begin
                push_ev(EV_STOP, 0);
                m_busy = 1'b0;
                m_nb   = 0;
            end
        end
        repeat (hold) @(negedge clk);
    endtask

    task automatic check_level(input string tag);
        check_output({tag, ".scl_f"}, int'(scl_f), int'(scl_i));
        check_output({tag, ".sda_f"}, int'(sda_f), int'(sda_i));
        check_output({tag, ".bus_busy"}, int'(bus_busy), int'(m_busy));
        check_output({tag, ".bit_cnt"}, int'(bit_cnt), m_nb);
        check_output({tag, ".byte_data"}, int'(byte_data), int'(m_last_byte));
        check_output({tag, ".ack_bit"}, int'(ack_bit), int'(m_last_ack));
    endtask

    task automatic send_bit(input logic b);
        apply_stimulus(1'b0, b, rnd(4, 8));
        apply_stimulus(1'b1, b, rnd(9, 14));
        check_level("bit");
        apply_stimulus(1'b0, b, rnd(4, 8));
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_start();
        if (scl_i == 1'b0) begin
            apply_stimulus(1'b0, 1'b1, rnd(4, 8));
            apply_stimulus(1'b1, 1'b1, rnd(9, 14));
            check_level("start_setup");
        end
        apply_stimulus(1'b1, 1'b0, rnd(9, 14));
        check_level("start");
        apply_stimulus(1'b0, 1'b0, rnd(4, 8));
    endtask

    task automatic do_stop();
        apply_stimulus(1'b0, 1'b0, rnd(4, 8));
        apply_stimulus(1'b1, 1'b0, rnd(9, 14));
        check_level("stop_setup");
        apply_stimulus(1'b1, 1'b1, rnd(9, 14));
        check_level("stop");
    endtask

    // Short pulse on one idle line that the filter must swallow
    task automatic glitch(input logic on_scl, input int len);
        if (on_scl) scl_i = 1'b0; else sda_i = 1'b0;
        repeat (len) @(negedge clk);
        scl_i = 1'b1;
        sda_i = 1'b1;
        repeat (12) @(negedge clk);
        check_level(on_scl ? "scl_glitch" : "sda_glitch");
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        scl_i = 1'b1;
        sda_i = 1'b1;
        repeat (20) @(negedge clk);
        check_level("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_level("post_reset");

        // Address byte 0xA6 acknowledged, then STOP
        do_start();
        send_byte(8'hA6);
        send_bit(1'b0);
        do_stop();

        // Glitches shorter than the filter length on each idle line
        for (int g = 1; g < FILT; g++) begin
            glitch(1'b0, g);
            glitch(1'b1, g);
        end

        // Five bits, repeated START, then a full byte 0x3C with NACK
        do_start();
        for (int i = 0; i < 5; i++) send_bit(logic'($urandom_range(1, 0)));
        do_start();
        send_byte(8'h3C);
        send_bit(1'b1);
        do_stop();

        // STOP after four data bits of the second byte discards the partial byte
        do_start();
        send_byte(8'(rnd(0, 255)));
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(logic'($urandom_range(1, 0)));
        do_stop();

        // Both lines switching together only report the SCL edge
        apply_stimulus(1'b0, 1'b0, 12);
        check_level("both_fall");
        apply_stimulus(1'b1, 1'b1, 12);
        check_level("both_rise");

        // Reset in the middle of a byte, clocking without START, then a fresh transfer
        do_start();
        send_bit(1'b1);
        send_bit(1'b0);
        apply_stimulus(1'b0, 1'b1, 6);
        apply_stimulus(1'b1, 1'b1, 10);
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_level("mid_reset");
        for (int i = 0; i < 3; i++) send_bit(logic'($urandom_range(1, 0)));
        do_start();
        send_byte(8'h5A);
        send_bit(1'b0);
        do_stop();

`ifdef I2C_SCL_TIMEOUT_EN
        // SCL held low long after START must time the transfer out
        apply_stimulus(1'b1, 1'b0, 10);
        apply_stimulus(1'b0, 1'b0, 150);
        check_level("timeout");
        do_stop();
`endif

        // Randomised transactions: bytes, random ACKs, partial bytes, repeated STARTs
        for (int t = 0; t < 10; t++) begin
            do_start();
            for (int n = rnd(1, 2); n > 0; n--) begin
                send_byte(8'(rnd(0, 255)));
                send_bit(logic'($urandom_range(1, 0)));
            end
            if (rnd(0, 1) == 1) begin
                for (int i = rnd(0, 7); i > 0; i--) send_bit(logic'($urandom_range(1, 0)));
            end
            if (rnd(0, 2) == 0) begin
                do_start();
                send_byte(8'(rnd(0, 255)));
                send_bit(logic'($urandom_range(1, 0)));
            end
            do_stop();
        end

        repeat (20) @(negedge clk);
        check_output("events_drained", exp_q.size(), 0);
        check_output("scl_rise_count", seen_rise, exp_rise);
        check_output("scl_fall_count", seen_fall, exp_fall);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
